// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word fetch at a time and hands the returned
// instruction to decode through a valid/ready register slice.

module fetch_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  // Wraps modulo 2^WIDTH by construction.
  assign sum_o = a_i + b_i;
endmodule

module fetch_stage #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_target;
  logic             unused_redirect_lsbs;

  fetch_adder #(
    .WIDTH (WIDTH)
  ) u_pc_adder (
    .a_i   (pc_q),
    .b_i   (PcStep),
    .sum_o (pc_plus4)
  );

  assign redirect_target      = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          // A response landing with the redirect is simply dropped; otherwise wait it out.
          state_d    = imem_resp_valid ? StReq : StDrain;
        end else if (imem_resp_valid) begin
          if_instr_d = imem_resp_data;
          if_pc_d    = pc_q;
          pc_d       = pc_plus4;
          if_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          state_d    = StReq;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a one-deep memory model plus a next-instruction-address
// reference, driven by directed scenarios followed by a randomized run.

module tb_fetch_stage;

  localparam int unsigned W      = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH    (W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: at most one request in flight, answered after out_lat idle cycles.
  bit          out_pending;
  logic [31:0] out_addr;
  int          out_lat;
  int          lat_lo, lat_hi;
  bit          drain;
  logic [31:0] exp_pc;
  int          cyc;
  logic [31:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  logic [31:0] xfer_pc_q[$];

  bit          p_stall, p_hold_stall, p_redir, p_deliver, p_discard, p_xfer;
  logic [31:0] p_req_addr, p_if_pc, p_if_instr, p_del_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    out_pending = 1'b0;
    drain       = 1'b0;
    exp_pc      = RST_PC;
    cyc         = 0;
    acc_addr_q.delete();
    acc_cyc_q.delete();
    xfer_pc_q.delete();
    p_stall = 0; p_hold_stall = 0; p_redir = 0;
    p_deliver = 0; p_discard = 0; p_xfer = 0;
  endtask

  // Holds rst across two edges, then spends the idle cycle trying a redirect that must be ignored.
  task automatic do_reset(input bit with_resp);
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = with_resp;
    imem_resp_data  = mem_word(out_addr);
    if_ready        = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    @(posedge clk); #1;
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0500;
    @(negedge clk);
    chk("idle_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt);
    bit resp, acc, xfer, deliver;
    resp            = out_pending && (out_lat == 0);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(out_addr) : $urandom;
    redirect_valid  = redir && !(drain && resp);
    redirect_pc     = tgt;
    imem_req_ready  = rdy && !redirect_valid;
    if_ready        = ifr;
    @(negedge clk);
    if (p_stall && !p_redir) begin
      chk("req_held", 32'(imem_req_valid), 32'd1);
      chk("req_addr_stable", imem_req_addr, p_req_addr);
    end
    if (p_hold_stall && !p_redir) begin
      chk("hold_valid", 32'(if_valid), 32'd1);
      chk("hold_pc", if_pc, p_if_pc);
      chk("hold_instr", if_instr, p_if_instr);
    end
    if (p_deliver) begin
      chk("deliver_valid", 32'(if_valid), 32'd1);
      chk("deliver_pc", if_pc, p_del_addr);
      chk("deliver_instr", if_instr, mem_word(p_del_addr));
    end
    if (p_discard || p_redir || p_xfer) chk("if_valid_clear", 32'(if_valid), 32'd0);
    if (if_valid) chk("no_req_in_hold", 32'(imem_req_valid), 32'd0);
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      chk("single_outstanding", 32'(out_pending), 32'd0);
      chk("req_addr", imem_req_addr, exp_pc);
      acc_addr_q.push_back(imem_req_addr);
      acc_cyc_q.push_back(cyc);
    end
    xfer = if_valid && if_ready;
    if (xfer) begin
      chk("xfer_pc", if_pc, exp_pc);
      chk("xfer_instr", if_instr, mem_word(exp_pc));
      xfer_pc_q.push_back(if_pc);
      exp_pc = exp_pc + 32'd4;
    end
    deliver    = resp && !drain && !redirect_valid;
    p_del_addr = out_addr;
    if (redirect_valid) begin
      exp_pc = {tgt[31:2], 2'b00};
      if (out_pending && !resp) drain = 1'b1;
    end
    if (resp) begin
      out_pending = 1'b0;
      drain       = 1'b0;
    end
    if (acc) begin
      out_pending = 1'b1;
      out_addr    = imem_req_addr;
      out_lat     = $urandom_range(lat_hi, lat_lo);
    end else if (out_pending && out_lat > 0) begin
      out_lat--;
    end
    p_stall      = imem_req_valid && !imem_req_ready;
    p_req_addr   = imem_req_addr;
    p_hold_stall = if_valid && !if_ready;
    p_if_pc      = if_pc;
    p_if_instr   = if_instr;
    p_redir      = redirect_valid;
    p_deliver    = deliver;
    p_discard    = resp && !deliver;
    p_xfer       = xfer;
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    logic [31:0] t;
    out_addr = 32'h0;
    out_lat  = 0;
    lat_lo   = 0;
    lat_hi   = 0;
    model_reset();

    // Back-to-back fetch from reset: one instruction every three cycles.
    do_reset(1'b0);
    repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p1_acc_count", 32'(acc_addr_q.size()), 32'd3);
    chk("p1_acc0", acc_addr_q[0], 32'h100);
    chk("p1_acc1", acc_addr_q[1], 32'h104);
    chk("p1_acc2", acc_addr_q[2], 32'h108);
    chk("p1_first_req_cyc", 32'(acc_cyc_q[0]), 32'd0);
    chk("p1_gap1", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd3);
    chk("p1_gap2", 32'(acc_cyc_q[2] - acc_cyc_q[1]), 32'd3);
    chk("p1_xfer_count", 32'(xfer_pc_q.size()), 32'd3);
    chk("p1_xfer2", xfer_pc_q[2], 32'h108);

    // Memory back-pressure for four cycles.
    do_reset(1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("p2_no_accept", 32'(acc_addr_q.size()), 32'd0);
    chk("p2_addr_held", imem_req_addr, 32'h100);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p2_one_accept", 32'(acc_addr_q.size()), 32'd1);

    // Decode back-pressure for five cycles in HOLD.
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("p3_no_new_req", 32'(acc_addr_q.size()), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p3_xfer_pc", xfer_pc_q[0], 32'h100);

    // Redirect while waiting; the stale response shows up two cycles later.
    lat_lo = 2; lat_hi = 2;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n0 = acc_addr_q.size();
    cycle(1'b1, 1'b1, 1'b1, 32'h203);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p4_redirect_addr", acc_addr_q[n0], 32'h200);
    chk("p4_stale_dropped", 32'(xfer_pc_q.size()), 32'd1);

    // PC wraps past the top of the address space.
    lat_lo = 0; lat_hi = 0;
    n0 = acc_addr_q.size();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p5_top_addr", acc_addr_q[n0], 32'hFFFF_FFFC);
    chk("p5_wrap_addr", acc_addr_q[n0 + 1], 32'h0);

    // Reset lands in WAIT together with a response.
    n0 = acc_addr_q.size();
    for (int i = 0; i < 10 && acc_addr_q.size() == n0; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p6_reached_wait", 32'(acc_addr_q.size() > n0), 32'd1);
    do_reset(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p6_restart_addr", acc_addr_q[0], RST_PC);
    chk("p6_no_xfer", 32'(xfer_pc_q.size()), 32'd0);

    // Randomized traffic with stalls, redirects and variable latency.
    lat_lo = 0; lat_hi = 3;
    do_reset(1'b0);
    repeat (600) begin
      t = $urandom;
      if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cycle($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7, $urandom_range(99, 0) < 8, t);
    end
    chk("rand_progress", 32'(xfer_pc_q.size() > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
